memory_access_sequencer: RTL and testbench

//  Sequences single-word reads/writes between the CPU memory-side registers and the memory chip.

---
 rtl/memory_access_sequencer.sv | 140 ++++++++++++++
 tb/tb_memory_access_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_sequencer.sv
// Memory access sequencer: single-word read/write sequencing between the MAR/MDR
// and the memory chip, with programmable wait states, ready handshake and timeout.
module memory_access_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MDR_load,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              op_rd, op_rd_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] mdatain_nxt;
  logic              mem_rd_nxt, mem_wr_nxt, mdr_load_nxt;
  logic              busy_nxt, done_nxt, err_nxt;

  logic req, ready_ok, timed_out;

  // Completion and timeout qualifiers for the current ACCESS cycle
  assign req       = rd_req | wr_req;
  assign ready_ok  = (cnt >= CNT_W'(WAIT_STATES)) && mem_ready;
  assign timed_out = (cnt == CNT_W'(TIMEOUT)) && !mem_ready;

  // State, counter and registered outputs
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      op_rd     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      Mdatain   <= '0;
      MDR_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_rd     <= op_rd_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_rd    <= mem_rd_nxt;
      mem_wr    <= mem_wr_nxt;
      Mdatain   <= mdatain_nxt;
      MDR_load  <= mdr_load_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (ready_ok || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes and pulses default low
  always_comb begin
    cnt_nxt       = cnt;
    op_rd_nxt     = op_rd;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mdatain_nxt   = Mdatain;
    mem_rd_nxt    = 1'b0;
    mem_wr_nxt    = 1'b0;
    mdr_load_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          mem_addr_nxt = mar_addr;
          op_rd_nxt    = rd_req;
          if (!rd_req) mem_wdata_nxt = mdr_wdata;
          cnt_nxt      = '0;
          mem_rd_nxt   = rd_req;
          mem_wr_nxt   = !rd_req;
          busy_nxt     = 1'b1;
        end
      end
      ACCESS: begin
        busy_nxt = 1'b1;
        if (ready_ok) begin
          done_nxt = 1'b1;
          if (op_rd) begin
            mdatain_nxt  = mem_rdata;
            mdr_load_nxt = 1'b1;
          end
        end else if (timed_out) begin
          done_nxt = 1'b1;
          err_nxt  = 1'b1;
        end else begin
          mem_rd_nxt = op_rd;
          mem_wr_nxt = !op_rd;
          if (cnt != CNT_W'(TIMEOUT)) cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer: two instances (different wait/timeout settings)
// share one stimulus stream; a transaction-level model predicts each one's behaviour.
module tb_memory_access_sequencer;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned WS_A = 1;
  localparam int unsigned TO_A = 15;
  localparam int unsigned WS_B = 3;
  localparam int unsigned TO_B = 6;
  localparam int WIN = TO_A + 4;

  logic          clock = 1'b0;
  logic          clear, rd_req, wr_req, mem_ready;
  logic [AW-1:0] mar_addr;
  logic [DW-1:0] mdr_wdata, mem_rdata;

  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_wdata_a, mem_wdata_b, mdatain_a, mdatain_b;
  logic mem_rd_a, mem_wr_a, mdr_load_a, busy_a, done_a, err_a;
  logic mem_rd_b, mem_wr_b, mdr_load_b, busy_b, done_b, err_b;

  logic [101:0] all_a, all_b;
  assign all_a = {mem_addr_a, mem_wdata_a, mdatain_a, mem_rd_a, mem_wr_a, mdr_load_a, busy_a, done_a, err_a};
  assign all_b = {mem_addr_b, mem_wdata_b, mdatain_b, mem_rd_b, mem_wr_b, mdr_load_b, busy_b, done_b, err_b};

  memory_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_A), .TIMEOUT(TO_A)) dut_a (
    .clock(clock), .clear(clear), .rd_req(rd_req), .wr_req(wr_req), .mar_addr(mar_addr),
    .mdr_wdata(mdr_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
    .Mdatain(mdatain_a), .MDR_load(mdr_load_a), .busy(busy_a), .done(done_a), .err(err_a));

  memory_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS_B), .TIMEOUT(TO_B)) dut_b (
    .clock(clock), .clear(clear), .rd_req(rd_req), .wr_req(wr_req), .mar_addr(mar_addr),
    .mdr_wdata(mdr_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
    .Mdatain(mdatain_b), .MDR_load(mdr_load_b), .busy(busy_b), .done(done_b), .err(err_b));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what each instance should be holding between transactions
  logic [DW-1:0] exp_mdat_a, exp_mdat_b, exp_wdata;
  logic [AW-1:0] exp_addr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ACCESS length: first cycle k in [ws,to] with ready gives k+1 cycles; otherwise timeout at to+1
  function automatic int exp_len(input logic [31:0] pat, input int ws, input int to, output bit ok);
    ok = 1'b0;
    for (int k = ws; k <= to; k++) begin
      if (pat[k]) begin
        ok = 1'b1;
        return k + 1;
      end
    end
    return to + 1;
  endfunction

  task automatic check_inst(input string n, input int len, input bit ok, input bit rd,
                            input int nrd, input int nwr, input int nbusy, input int ndone,
                            input int done_at, input bit errv, input int nld);
    check({n, ".rd_cycles"}, 128'(nrd), 128'(rd ? len : 0));
    check({n, ".wr_cycles"}, 128'(nwr), 128'(rd ? 0 : len));
    check({n, ".busy_cycles"}, 128'(nbusy), 128'(len + 1));
    check({n, ".done_pulses"}, 128'(ndone), 128'(1));
    check({n, ".done_cycle"}, 128'(done_at), 128'(len));
    check({n, ".err"}, 128'(errv), 128'(!ok));
    check({n, ".mdr_loads"}, 128'(nld), 128'((rd && ok) ? 1 : 0));
  endtask

  task automatic run_txn(input bit rd, input bit both, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [31:0] pat,
                         input bit rand_rdata, input logic [DW-1:0] fixed_rdata, input bit extra_req);
    bit oka, okb, rd_eff;
    int la, lb, lmin;
    int nrd_a = 0, nwr_a = 0, nbusy_a = 0, ndone_a = 0, at_a = -1, nld_a = 0;
    int nrd_b = 0, nwr_b = 0, nbusy_b = 0, ndone_b = 0, at_b = -1, nld_b = 0;
    bit err_seen_a = 1'b0, err_seen_b = 1'b0;
    logic [DW-1:0] cap_a, cap_b;
    rd_eff = rd | both;
    la = exp_len(pat, WS_A, TO_A, oka);
    lb = exp_len(pat, WS_B, TO_B, okb);
    lmin = (la < lb) ? la : lb;
    cap_a = exp_mdat_a;
    cap_b = exp_mdat_b;
    @(negedge clock);
    rd_req    = rd_eff;
    wr_req    = !rd_eff | both;
    mar_addr  = addr;
    mdr_wdata = wd;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clock);
      if (mem_rd_a) nrd_a++;
      if (mem_wr_a) nwr_a++;
      if (busy_a) nbusy_a++;
      if (mdr_load_a) nld_a++;
      if (done_a) begin ndone_a++; at_a = k; err_seen_a = err_a; end
      if (mem_rd_b) nrd_b++;
      if (mem_wr_b) nwr_b++;
      if (busy_b) nbusy_b++;
      if (mdr_load_b) nld_b++;
      if (done_b) begin ndone_b++; at_b = k; err_seen_b = err_b; end
      rd_req    = (extra_req && k <= lmin) ? 1'($urandom) : 1'b0;
      wr_req    = (extra_req && k <= lmin) ? 1'($urandom) : 1'b0;
      mar_addr  = $urandom;
      mdr_wdata = $urandom;
      mem_ready = pat[k];
      mem_rdata = rand_rdata ? DW'($urandom) : fixed_rdata;
      if (k == la - 1) cap_a = mem_rdata;
      if (k == lb - 1) cap_b = mem_rdata;
    end
    mem_ready = 1'b0;
    check_inst("a", la, oka, rd_eff, nrd_a, nwr_a, nbusy_a, ndone_a, at_a, err_seen_a, nld_a);
    check_inst("b", lb, okb, rd_eff, nrd_b, nwr_b, nbusy_b, ndone_b, at_b, err_seen_b, nld_b);
    exp_addr = addr;
    if (!rd_eff) exp_wdata = wd;
    if (rd_eff && oka) exp_mdat_a = cap_a;
    if (rd_eff && okb) exp_mdat_b = cap_b;
    check("a.mem_addr", 128'(mem_addr_a), 128'(exp_addr));
    check("b.mem_addr", 128'(mem_addr_b), 128'(exp_addr));
    check("a.mem_wdata", 128'(mem_wdata_a), 128'(exp_wdata));
    check("b.mem_wdata", 128'(mem_wdata_b), 128'(exp_wdata));
    check("a.Mdatain", 128'(mdatain_a), 128'(exp_mdat_a));
    check("b.Mdatain", 128'(mdatain_b), 128'(exp_mdat_b));
  endtask

  task automatic reset_model();
    exp_mdat_a = '0;
    exp_mdat_b = '0;
    exp_wdata  = '0;
    exp_addr   = '0;
  endtask

  initial begin
    int ndone;
    logic [31:0] pat;
    clear = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0;
    mar_addr = '0; mdr_wdata = '0; mem_rdata = '0;
    reset_model();
    #1;
    check("reset.a", 128'(all_a), 128'(0));
    check("reset.b", 128'(all_b), 128'(0));
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("idle.a", 128'(all_a), 128'(0));
    check("idle.b", 128'(all_b), 128'(0));

    // Directed cases
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b0, 1'b0, 32'h20, 32'h1234_5678, 32'hFFFF_FFF8, 1'b1, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    run_txn(1'b1, 1'b1, 32'h40, 32'hAAAA_5555, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    run_txn(1'b1, 1'b0, 32'h50, 32'h0, 32'h0000_0005, 1'b1, 32'h0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h60, 32'hCAFE_F00D, 32'h0000_0040, 1'b1, 32'h0, 1'b1);

    // Clear on the second ACCESS cycle of a read
    @(negedge clock);
    rd_req = 1'b1; mar_addr = 32'h70; mem_ready = 1'b0;
    @(negedge clock);
    rd_req = 1'b0;
    @(negedge clock);
    check("pre_clear.rd_a", 128'(mem_rd_a), 128'(1));
    clear = 1'b1;
    #1;
    check("clear.a", 128'(all_a), 128'(0));
    check("clear.b", 128'(all_b), 128'(0));
    @(negedge clock);
    clear = 1'b0;
    reset_model();
    ndone = 0;
    mem_ready = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (done_a || done_b || busy_a || busy_b) ndone++;
    end
    mem_ready = 1'b0;
    check("clear.no_activity", 128'(ndone), 128'(0));
    run_txn(1'b1, 1'b0, 32'h80, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: pat = $urandom & $urandom & $urandom;
        1: pat = 32'h0;
        2: pat = 32'hFFFF_FFFF << $urandom_range(0, 17);
        default: pat = 32'(1) << $urandom_range(0, 17);
      endcase
      run_txn(1'($urandom), ($urandom_range(0, 3) == 0), $urandom, $urandom, pat,
              1'b1, 32'h0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
